// File: rtl/data_mem_responder.sv
// Data-side memory responder: turns cache line/word commands into single-word RAM accesses.
// Define DATA_MEM_RESPONDER_CWF_EN to make ReadLine start at Address[1:0] (critical word first).
module data_mem_responder #(
    parameter int PABITS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PABITS-3:0] Address,
    input  logic              ReadLine,
    input  logic              ReadWord,
    input  logic              WriteLineReady,
    input  logic              WriteWordReady,
    input  logic [3:0]        WriteWordBE,
    input  logic [127:0]      DataIn,
    output logic [31:0]       DataOut,
    output logic              Ready,
    output logic [1:0]        Offset,
    output logic [PABITS-3:0] Ram_Address,
    output logic              Ram_Read,
    output logic              Ram_Write,
    output logic [3:0]        Ram_BE,
    output logic [31:0]       Ram_WriteData,
    input  logic [31:0]       Ram_ReadData
);

    localparam int AW = PABITS - 2;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, ACK, COOL} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           line_q, line_d;
    logic           ram_read_q, ram_read_d;
    logic           ram_write_q, ram_write_d;
    logic [AW-1:0]  ram_addr_q, ram_addr_d;
    logic [3:0]     ram_be_q, ram_be_d;
    logic [31:0]    ram_wdata_q, ram_wdata_d;
    logic           rd_vld_p1_q, rd_vld_p1_d;
    logic [1:0]     rd_idx_p1_q, rd_idx_p1_d;
    logic           ready_q, ready_d;
    logic [1:0]     offset_q, offset_d;
    logic [31:0]    dout_q, dout_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [127:0]   data_q, data_d;
    logic [1:0]     start_idx;
    logic [1:0]     nidx;

    always_comb begin
`ifdef DATA_MEM_RESPONDER_CWF_EN
        start_idx = Address[1:0];
`else
        start_idx = 2'd0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_be_d    = ram_be_q;
        ram_wdata_d = ram_wdata_q;
        addr_d      = addr_q;
        data_d      = data_q;
        nidx        = ram_addr_q[1:0] + 2'd1;
        // read return stage: RAM data arrives one cycle after issue, registered out the next
        rd_vld_p1_d = ram_read_q;
        rd_idx_p1_d = ram_addr_q[1:0];
        ready_d     = rd_vld_p1_q;
        dout_d      = rd_vld_p1_q ? Ram_ReadData : dout_q;
        offset_d    = rd_vld_p1_q ? rd_idx_p1_q : offset_q;

        case (state_q)
            IDLE: begin
                addr_d = Address;
                data_d = DataIn;
                cnt_d  = 2'd0;
                if (WriteLineReady) begin
                    state_d     = WRITE;
                    line_d      = 1'b1;
                    ram_write_d = 1'b1;
                    ram_addr_d  = {Address[AW-1:2], 2'b00};
                    ram_be_d    = 4'hF;
                    ram_wdata_d = DataIn[31:0];
                end else if (ReadLine) begin
                    state_d    = READ;
                    line_d     = 1'b1;
                    ram_read_d = 1'b1;
                    ram_addr_d = {Address[AW-1:2], start_idx};
                end else if (WriteWordReady) begin
                    state_d     = WRITE;
                    line_d      = 1'b0;
                    ram_write_d = 1'b1;
                    ram_addr_d  = Address;
                    ram_be_d    = WriteWordBE;
                    ram_wdata_d = DataIn[31:0];
                end else if (ReadWord) begin
                    state_d    = READ;
                    line_d     = 1'b0;
                    ram_read_d = 1'b1;
                    ram_addr_d = Address;
                end
            end
            READ: begin
                if (line_q && cnt_q != 2'd3) begin
                    ram_read_d = 1'b1;
                    cnt_d      = cnt_q + 2'd1;
                    ram_addr_d = {addr_q[AW-1:2], nidx};
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_vld_p1_q) state_d = COOL;
            end
            WRITE: begin
                if (line_q && cnt_q != 2'd3) begin
                    ram_write_d = 1'b1;
                    cnt_d       = cnt_q + 2'd1;
                    ram_addr_d  = {addr_q[AW-1:2], nidx};
                    ram_be_d    = 4'hF;
                    ram_wdata_d = data_q[{nidx, 5'b0} +: 32];
                end else begin
                    // Ready is registered, so raising it here lands it in the ACK cycle
                    state_d  = ACK;
                    ready_d  = 1'b1;
                    offset_d = 2'd0;
                end
            end
            ACK:     state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            line_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_be_q    <= 4'd0;
            ram_wdata_q <= 32'd0;
            rd_vld_p1_q <= 1'b0;
            ready_q     <= 1'b0;
            offset_q    <= 2'd0;
            dout_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            ram_read_q  <= ram_read_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_be_q    <= ram_be_d;
            ram_wdata_q <= ram_wdata_d;
            rd_vld_p1_q <= rd_vld_p1_d;
            ready_q     <= ready_d;
            offset_q    <= offset_d;
            dout_q      <= dout_d;
        end
    end

    // Captured command payload and return index need no reset: they are qualified by control state
    always_ff @(posedge clock) begin
        addr_q      <= addr_d;
        data_q      <= data_d;
        rd_idx_p1_q <= rd_idx_p1_d;
    end

    assign DataOut       = dout_q;
    assign Ready         = ready_q;
    assign Offset        = offset_q;
    assign Ram_Address   = ram_addr_q;
    assign Ram_Read      = ram_read_q;
    assign Ram_Write     = ram_write_q;
    assign Ram_BE        = ram_be_q;
    assign Ram_WriteData = ram_wdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder with a behavioural word RAM.
module tb_data_mem_responder;

    localparam int PABITS = 32;
    localparam int AW     = PABITS - 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] Address;
    logic          ReadLine, ReadWord, WriteLineReady, WriteWordReady;
    logic [3:0]    WriteWordBE;
    logic [127:0]  DataIn;
    logic [31:0]   DataOut;
    logic          Ready;
    logic [1:0]    Offset;
    logic [AW-1:0] Ram_Address;
    logic          Ram_Read, Ram_Write;
    logic [3:0]    Ram_BE;
    logic [31:0]   Ram_WriteData;
    logic [31:0]   Ram_ReadData;

    data_mem_responder #(.PABITS(PABITS)) dut (
        .clock(clock), .reset(reset), .Address(Address),
        .ReadLine(ReadLine), .ReadWord(ReadWord),
        .WriteLineReady(WriteLineReady), .WriteWordReady(WriteWordReady),
        .WriteWordBE(WriteWordBE), .DataIn(DataIn),
        .DataOut(DataOut), .Ready(Ready), .Offset(Offset),
        .Ram_Address(Ram_Address), .Ram_Read(Ram_Read), .Ram_Write(Ram_Write),
        .Ram_BE(Ram_BE), .Ram_WriteData(Ram_WriteData), .Ram_ReadData(Ram_ReadData)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] mem [0:255];
    always @(posedge clock) begin
        if (Ram_Read) Ram_ReadData <= mem[Ram_Address[7:0]];
        if (Ram_Write)
            for (int b = 0; b < 4; b++)
                if (Ram_BE[b]) mem[Ram_Address[7:0]][8*b +: 8] <= Ram_WriteData[8*b +: 8];
    end

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ev_t;

    ev_t rdy_q[$];
    ev_t wr_q[$];
    ev_t rd_q[$];
    int  both_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (Ready)     rdy_q.push_back('{cyc, 32'(Offset), DataOut, 4'd0});
            if (Ram_Write) wr_q.push_back('{cyc, 32'(Ram_Address), Ram_WriteData, Ram_BE});
            if (Ram_Read)  rd_q.push_back('{cyc, 32'(Ram_Address), 32'd0, 4'd0});
            if (Ram_Read && Ram_Write) both_cnt++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        rdy_q.delete();
        wr_q.delete();
        rd_q.delete();
    endtask

    task automatic wait_ready(input int n, input int budget);
        for (int i = 0; i < budget && rdy_q.size() < n; i++) step();
    endtask

    int acc, rc, nrd;
    int exp_off [4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int k = 0; k < 4; k++) mem[8'h10 + k] = 32'hA0 + k;
        mem[7] = 32'h12345678;
        mem[8] = 32'h5A5A5A5A;
`ifdef DATA_MEM_RESPONDER_CWF_EN
        exp_off = '{3, 0, 1, 2};
`else
        exp_off = '{0, 1, 2, 3};
`endif
        reset = 1'b1; Address = '0; ReadLine = 0; ReadWord = 0;
        WriteLineReady = 0; WriteWordReady = 0; WriteWordBE = 4'h0; DataIn = '0;
        repeat (3) step();
        chk("rst_ready", Ready, 0);
        chk("rst_ram_rw", {Ram_Read, Ram_Write}, 0);
        chk("rst_dataout", DataOut, 0);
        chk("rst_offset", Offset, 0);
        chk("rst_ram_addr", Ram_Address, 0);
        chk("rst_ram_be_wd", {Ram_BE, Ram_WriteData}, 0);
        reset = 1'b0;
        step();

        // ReadLine at 0x13; Address scrambled after acceptance
        clear_logs();
        Address = 30'h13; ReadLine = 1; acc = cyc;
        step();
        Address = 30'h3F;
        wait_ready(4, 30);
        ReadLine = 0;
        repeat (4) step();
        chk("rl_nready", rdy_q.size(), 4);
        chk("rl_nread", rd_q.size(), 4);
        if (rdy_q.size() == 4 && rd_q.size() == 4)
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rl_off%0d", k), rdy_q[k].a, exp_off[k]);
                chk($sformatf("rl_data%0d", k), rdy_q[k].d, 32'hA0 + exp_off[k]);
                chk($sformatf("rl_cyc%0d", k), rdy_q[k].cyc, acc + 3 + k);
                chk($sformatf("rl_addr%0d", k), rd_q[k].a, 32'h10 + exp_off[k]);
            end

        // ReadWord at 0x12
        clear_logs();
        Address = 30'h12; ReadWord = 1; acc = cyc;
        wait_ready(1, 20);
        ReadWord = 0;
        repeat (4) step();
        chk("rw_nready", rdy_q.size(), 1);
        chk("rw_nread", rd_q.size(), 1);
        if (rdy_q.size() == 1) begin
            chk("rw_off", rdy_q[0].a, 2);
            chk("rw_data", rdy_q[0].d, 32'hA2);
            chk("rw_cyc", rdy_q[0].cyc, acc + 3);
        end

        // WriteLineReady and ReadLine together: write first
        clear_logs();
        Address = 30'h20; DataIn = 128'h44444444_33333333_22222222_11111111;
        WriteLineReady = 1; ReadLine = 1; acc = cyc;
        wait_ready(1, 20);
        WriteLineReady = 0;
        chk("wl_nready", rdy_q.size(), 1);
        chk("wl_nwrite", wr_q.size(), 4);
        chk("wl_noread", rd_q.size(), 0);
        if (rdy_q.size() == 1) begin
            chk("wl_ready_off", rdy_q[0].a, 0);
            chk("wl_ready_hold", rdy_q[0].d, 32'hA2);
            chk("wl_ready_cyc", rdy_q[0].cyc, acc + 5);
        end
        if (wr_q.size() == 4)
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("wl_addr%0d", k), wr_q[k].a, 32'h20 + k);
                chk($sformatf("wl_data%0d", k), wr_q[k].d, 32'h11111111 * (k + 1));
                chk($sformatf("wl_be%0d", k), wr_q[k].be, 4'hF);
                chk($sformatf("wl_cyc%0d", k), wr_q[k].cyc, acc + 1 + k);
            end

        // Held ReadLine then starts; reset lands during its second issue
        nrd = 0;
        for (int i = 0; i < 20 && nrd < 2; i++) begin
            step();
            if (Ram_Read) nrd++;
        end
        chk("rst_mid_seen2", nrd, 2);
        reset = 1'b1; ReadLine = 0;
        step();
        reset = 1'b0;
        clear_logs();
        rc = cyc;
        chk("post_rst_ready", Ready, 0);
        chk("post_rst_ram", {Ram_Read, Ram_Write}, 0);
        repeat (8) step();
        chk("post_rst_nready", rdy_q.size(), 0);
        chk("post_rst_nacc", rd_q.size() + wr_q.size(), 0);

        // ReadWord after reset proves return to IDLE
        clear_logs();
        Address = 30'h21; ReadWord = 1; acc = cyc;
        wait_ready(1, 20);
        ReadWord = 0;
        repeat (4) step();
        chk("rw2_nready", rdy_q.size(), 1);
        if (rdy_q.size() == 1) begin
            chk("rw2_data", rdy_q[0].d, 32'h22222222);
            chk("rw2_off", rdy_q[0].a, 1);
            chk("rw2_cyc", rdy_q[0].cyc, acc + 3);
        end

        // WriteWord BE=0101, then ReadLine raised during COOL
        clear_logs();
        Address = 30'h7; DataIn = {96'h0, 32'hDEADBEEF}; WriteWordBE = 4'b0101;
        WriteWordReady = 1; acc = cyc;
        wait_ready(1, 20);
        WriteWordReady = 0; ReadLine = 1;
        chk("ww_nwrite", wr_q.size(), 1);
        chk("ww_nready", rdy_q.size(), 1);
        if (wr_q.size() == 1) begin
            chk("ww_addr", wr_q[0].a, 7);
            chk("ww_be", wr_q[0].be, 4'h5);
            chk("ww_data", wr_q[0].d, 32'hDEADBEEF);
        end
        if (rdy_q.size() == 1) begin
            chk("ww_ready_cyc", rdy_q[0].cyc, acc + 2);
            chk("ww_ready_off", rdy_q[0].a, 0);
            chk("ww_ready_hold", rdy_q[0].d, 32'h22222222);
        end
        wait_ready(5, 30);
        ReadLine = 0;
        repeat (4) step();
        chk("cool_nready", rdy_q.size(), 5);
        chk("cool_nread", rd_q.size(), 4);
        if (rd_q.size() > 0) chk("cool_first_read_cyc", rd_q[0].cyc, acc + 5);
        chk("ww_mem", mem[7], 32'h12AD56EF);

        // WriteWord with BE=0 still completes
        clear_logs();
        Address = 30'h8; DataIn = {96'h0, 32'hFFFFFFFF}; WriteWordBE = 4'b0000;
        WriteWordReady = 1; acc = cyc;
        wait_ready(1, 20);
        WriteWordReady = 0;
        repeat (4) step();
        chk("wz_nwrite", wr_q.size(), 1);
        if (wr_q.size() == 1) chk("wz_be", wr_q[0].be, 4'h0);
        chk("wz_nready", rdy_q.size(), 1);
        if (rdy_q.size() == 1) chk("wz_ready_cyc", rdy_q[0].cyc, acc + 2);
        chk("wz_mem", mem[8], 32'h5A5A5A5A);

        chk("rd_wr_overlap", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
